// File: rtl/mem_wait_if.sv
// mem_wait_if: CPU-to-memory request/response bundle for mem_wait_controller
// master: drives Mem_read, Mem_write, Maddress_in, Mdata_in; samples the rest
// slave:  returns Mdata_out, Mem_ready, Mem_busy, Mem_error
interface mem_wait_if;
    logic        Mem_read;
    logic        Mem_write;
    logic [31:0] Maddress_in;
    logic [31:0] Mdata_in;
    logic [31:0] Mdata_out;
    logic        Mem_ready;
    logic        Mem_busy;
    logic        Mem_error;
    modport master (
        output Mem_read, Mem_write, Maddress_in, Mdata_in,
        input  Mdata_out, Mem_ready, Mem_busy, Mem_error
    );
    modport slave (
        input  Mem_read, Mem_write, Maddress_in, Mdata_in,
        output Mdata_out, Mem_ready, Mem_busy, Mem_error
    );
endinterface

// File: rtl/mem_wait_controller.sv
// mem_wait_controller: word-addressed main memory with a programmable wait-state sequencer
// clk, reset (async, active-high); bus (slave): read/write strobes, address, write data in;
// read data, one-cycle ready pulse, busy level and error pulse out
module mem_wait_controller #(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_STATES = 2
) (
    input logic     clk,
    input logic     reset,
    mem_wait_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
    state_t               state;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          wdata;
    logic                 is_wr;
    logic                 is_err;
    logic                 req;
    logic                 err_in;
    logic [31:0]          mem [0:(1<<ADDR_BITS)-1];

    // DONE accepts new work too, so back-to-back accesses lose no cycle
    assign req    = (state == IDLE || state == DONE) && (bus.Mem_read || bus.Mem_write);
    assign err_in = (bus.Mem_read && bus.Mem_write) || (bus.Maddress_in[31:ADDR_BITS] != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            wdata         <= '0;
            is_wr         <= 1'b0;
            is_err        <= 1'b0;
            bus.Mdata_out <= '0;
            bus.Mem_ready <= 1'b0;
            bus.Mem_busy  <= 1'b0;
            bus.Mem_error <= 1'b0;
        end else begin
            bus.Mem_ready <= 1'b0;
            bus.Mem_error <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (req) begin
                        idx          <= bus.Maddress_in[ADDR_BITS-1:0];
                        wdata        <= bus.Mdata_in;
                        is_wr        <= bus.Mem_write;
                        is_err       <= err_in;
                        cnt          <= 4'(WAIT_STATES);
                        state        <= (WAIT_STATES > 0) ? WAIT : ACCESS;
                        bus.Mem_busy <= 1'b1;
                    end else begin
                        state        <= IDLE;
                        bus.Mem_busy <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt   <= cnt - 4'd1;
                    state <= (cnt == 4'd1) ? ACCESS : WAIT;
                end
                ACCESS: begin
                    state         <= DONE;
                    bus.Mem_busy  <= 1'b0;
                    bus.Mem_ready <= 1'b1;
                    bus.Mem_error <= is_err;
                    if (!is_wr && !is_err)
                        bus.Mdata_out <= mem[idx];
                end
                default: state <= IDLE;
            endcase
        end
    end

    // array has no reset; an async reset pulls state out of ACCESS before the edge
    always_ff @(posedge clk)
        if (state == ACCESS && is_wr && !is_err)
            mem[idx] <= wdata;
endmodule

// File: tb/tb_mem_wait_controller.sv
// tb_mem_wait_controller: table-driven scoreboard bench for two mem_wait_controller instances (2 and 0 wait states)
module tb_mem_wait_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_wait_if b0();
    mem_wait_if b1();

    mem_wait_controller #(.ADDR_BITS(9), .WAIT_STATES(2)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    mem_wait_controller #(.ADDR_BITS(9), .WAIT_STATES(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    logic [1:0]  rd = '0;
    logic [1:0]  wr = '0;
    logic [31:0] addr [2];
    logic [31:0] din [2];
    logic [1:0]  rdy, bsy, err;
    logic [31:0] dout [2];

    assign b0.Mem_read = rd[0];
    assign b0.Mem_write = wr[0];
    assign b0.Maddress_in = addr[0];
    assign b0.Mdata_in = din[0];
    assign b1.Mem_read = rd[1];
    assign b1.Mem_write = wr[1];
    assign b1.Maddress_in = addr[1];
    assign b1.Mdata_in = din[1];
    assign rdy = {b1.Mem_ready, b0.Mem_ready};
    assign bsy = {b1.Mem_busy, b0.Mem_busy};
    assign err = {b1.Mem_error, b0.Mem_error};
    assign dout[0] = b0.Mdata_out;
    assign dout[1] = b1.Mdata_out;

    typedef struct {
        int          d;
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] dat;
        bit          e_err;
        logic [31:0] e_out;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called one step after the acceptance edge; counts cycles until Mem_ready.
    task automatic wait_done(input int d);
        int k = 0;
        int busy_n = 0;
        bit got = 0;
        vec_t e;
        int ws = (d == 0) ? 2 : 0;
        while (!got && k < 40) begin
            k++;
            if (rdy[d]) got = 1;
            else begin
                if (bsy[d]) busy_n++;
                @(posedge clk);
                #1;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: no Mem_ready on dut%0d, required within %0d cycles", d, ws + 2);
            return;
        end
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        chk("latency", 32'(k), 32'(ws + 2));
        chk("busy_cycles", 32'(busy_n), 32'(ws + 1));
        chk("error", 32'(err[d]), 32'(e.e_err));
        chk("rdata", dout[d], e.e_out);
        @(posedge clk);
        #1;
        chk("ready_pulse", 32'(rdy[d]), 32'd0);
        chk("idle_busy", 32'(bsy[d]), 32'd0);
        chk("error_pulse", 32'(err[d]), 32'd0);
    endtask

    task automatic run(input vec_t v);
        @(negedge clk);
        rd[v.d] = v.r;
        wr[v.d] = v.w;
        addr[v.d] = v.a;
        din[v.d] = v.dat;
        sb.push_back(v);
        @(posedge clk);
        #1;
        rd[v.d] = 1'b0;
        wr[v.d] = 1'b0;
        wait_done(v.d);
    endtask

    initial begin
        vec_t v;
        addr[0] = '0; addr[1] = '0; din[0] = '0; din[1] = '0;
        tbl.push_back('{0, 1'b0, 1'b1, 32'd5,         32'hDEADBEEF, 1'b0, 32'h00000000});
        tbl.push_back('{0, 1'b1, 1'b0, 32'd5,         32'h0,        1'b0, 32'hDEADBEEF});
        tbl.push_back('{1, 1'b0, 1'b1, 32'd0,         32'h00000001, 1'b0, 32'h00000000});
        tbl.push_back('{1, 1'b1, 1'b0, 32'd0,         32'h0,        1'b0, 32'h00000001});
        tbl.push_back('{0, 1'b0, 1'b1, 32'd0,         32'h0BADF00D, 1'b0, 32'hDEADBEEF});
        tbl.push_back('{0, 1'b0, 1'b1, 32'h00000200,  32'h55555555, 1'b1, 32'hDEADBEEF});
        tbl.push_back('{0, 1'b1, 1'b0, 32'd0,         32'h0,        1'b0, 32'h0BADF00D});
        tbl.push_back('{0, 1'b0, 1'b1, 32'd7,         32'h12345678, 1'b0, 32'h0BADF00D});
        tbl.push_back('{0, 1'b1, 1'b1, 32'd7,         32'hFFFFFFFF, 1'b1, 32'h0BADF00D});
        tbl.push_back('{0, 1'b1, 1'b0, 32'd7,         32'h0,        1'b0, 32'h12345678});
        tbl.push_back('{0, 1'b1, 1'b0, 32'h80000005,  32'h0,        1'b1, 32'h12345678});
        tbl.push_back('{1, 1'b1, 1'b0, 32'h00000200,  32'h0,        1'b1, 32'h00000001});
        tbl.push_back('{1, 1'b0, 1'b1, 32'h000001FF,  32'hAAAA5555, 1'b0, 32'h00000001});
        tbl.push_back('{1, 1'b1, 1'b0, 32'h000001FF,  32'h0,        1'b0, 32'hAAAA5555});
        tbl.push_back('{0, 1'b0, 1'b1, 32'd3,         32'h33333333, 1'b0, 32'h12345678});
        tbl.push_back('{0, 1'b0, 1'b1, 32'd9,         32'hCAFEF00D, 1'b0, 32'h12345678});

        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_dout", dout[d], 32'h0);
            chk("reset_ready", 32'(rdy[d]), 32'd0);
            chk("reset_busy", 32'(bsy[d]), 32'd0);
            chk("reset_error", 32'(err[d]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

        // Address and a write strobe change during WAIT of a read to address 3
        @(negedge clk);
        rd[0] = 1'b1;
        addr[0] = 32'd3;
        din[0] = 32'h0;
        sb.push_back('{0, 1'b1, 1'b0, 32'd3, 32'h0, 1'b0, 32'h33333333});
        @(posedge clk);
        #1;
        addr[0] = 32'd9;
        wr[0] = 1'b1;
        wait_done(0);
        run('{0, 1'b1, 1'b0, 32'd9, 32'h0, 1'b0, 32'hCAFEF00D});

        // Reset during WAIT of a read: abort with no ready pulse
        @(negedge clk);
        rd[0] = 1'b1;
        addr[0] = 32'd9;
        @(posedge clk);
        #1;
        rd[0] = 1'b0;
        chk("pre_reset_busy", 32'(bsy[0]), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_dout", dout[0], 32'h0);
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        chk("abort_ready", 32'(rdy[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_ready", 32'(rdy[0]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("post_reset_quiet", 32'(rdy[0] | bsy[0]), 32'd0);
        end
        run('{0, 1'b1, 1'b0, 32'd9, 32'h0, 1'b0, 32'hCAFEF00D});
        run('{1, 1'b1, 1'b0, 32'h000001FF, 32'h0, 1'b0, 32'hAAAA5555});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
